acumulador_pf: RTL and testbench

Sequential accumulator that sums a stream of IEEE-754 single-precision values by time-multiplexing the combinational `SumaPF` adder. It sits around `SumaPF`: it drives the adder's `a`/`b` operands from registered state and captures its `result` into a running sum. Terms arrive over a valid/ready input; the final sum leaves over a valid/ready output.

---
 rtl/acumulador_pf.sv | 129 ++++++++++++
 tb/tb_acumulador_pf.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acumulador_pf.sv
// Sequential IEEE-754 single-precision accumulator that time-multiplexes an external SumaPF adder.
// Define ACUMULADOR_PF_ERR_EN to add a sticky Inf/NaN flag output `err`.
module acumulador_pf #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic [31:0]      suma_a,
  output logic [31:0]      suma_b,
  input  logic [31:0]      suma_result,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] count
`ifdef ACUMULADOR_PF_ERR_EN
  ,
  output logic             err
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACEPTA = 2'd1;
  localparam logic [1:0] S_SUMA   = 2'd2;
  localparam logic [1:0] S_SALIDA = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      b_q, b_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_inc;
`ifdef ACUMULADOR_PF_ERR_EN
  logic             err_q, err_d;
`endif

  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    n_d     = n_q;
    count_d = count_q;
`ifdef ACUMULADOR_PF_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = n_terms;
          acc_d   = '0;
          b_d     = '0;
          count_d = '0;
`ifdef ACUMULADOR_PF_ERR_EN
          err_d   = 1'b0;
`endif
          state_d = (n_terms == '0) ? S_SALIDA : S_ACEPTA;
        end
      end
      S_ACEPTA: begin
        if (in_valid) begin
          // The first term loads the sum directly so the adder never sees a zero operand.
          if (count_q == '0) begin
            acc_d   = in_data;
            count_d = CNT_W'(1);
            state_d = (n_q == CNT_W'(1)) ? S_SALIDA : S_ACEPTA;
          end else begin
            b_d     = in_data;
            state_d = S_SUMA;
          end
        end
      end
      S_SUMA: begin
        acc_d   = suma_result;
        count_d = count_inc;
`ifdef ACUMULADOR_PF_ERR_EN
        err_d   = err_q | (suma_result[30:23] == 8'hFF);
`endif
        state_d = (count_inc == n_q) ? S_SALIDA : S_ACEPTA;
      end
      S_SALIDA: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      n_q     <= '0;
      count_q <= '0;
`ifdef ACUMULADOR_PF_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      n_q     <= n_d;
      count_q <= count_d;
`ifdef ACUMULADOR_PF_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_ACEPTA);
  assign out_valid = (state_q == S_SALIDA);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = acc_q;
  assign suma_a    = acc_q;
  assign suma_b    = b_q;
  assign count     = count_q;
`ifdef ACUMULADOR_PF_ERR_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_acumulador_pf.sv
// Scoreboard bench for acumulador_pf; a lookup table stands in for the SumaPF adder.
// Define ACUMULADOR_PF_ERR_EN to also check the err output.
module tb_acumulador_pf;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] n_terms;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic [31:0]      suma_a, suma_b, suma_result;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             err_w;

  always #5 clk = ~clk;

  acumulador_pf #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n_terms    (n_terms),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .suma_a     (suma_a),
    .suma_b     (suma_b),
    .suma_result(suma_result),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .count      (count)
`ifdef ACUMULADOR_PF_ERR_EN
    ,
    .err        (err_w)
`endif
  );

`ifndef ACUMULADOR_PF_ERR_EN
  assign err_w = 1'b0;
`endif

  // Hand-computed sums for the operand pairs this bench produces.
  function automatic logic [31:0] sumapf_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3FC00000_40200000: return 32'h40800000;  // 1.5 + 2.5 = 4.0
      64'h40800000_40800000: return 32'h41000000;  // 4.0 + 4.0 = 8.0
      64'h7F7FFFFF_7F7FFFFF: return 32'h7F800000;  // max + max = +Inf
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  assign suma_result = sumapf_model(suma_a, suma_b);

  typedef struct {
    logic [31:0]      data;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [CNT_W-1:0] c, input logic e);
    exp_t x;
    x.data = d;
    x.cnt  = c;
    x.err  = e;
    sb_q.push_back(x);
  endtask

  // Monitor: every output handshake pops one expected result.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_data", out_data, mon_e.data);
        check("out_count", 32'(count), 32'(mon_e.cnt));
`ifdef ACUMULADOR_PF_ERR_EN
        check("out_err", 32'(err_w), 32'(mon_e.err));
`endif
      end
    end
  end

  task automatic do_start(input logic [CNT_W-1:0] n);
    start   = 1'b1;
    n_terms = n;
    @(posedge clk);
    #1;
    start   = 1'b0;
    n_terms = '0;
  endtask

  task automatic send(input logic [31:0] d, input int gap);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_out();
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    if (!ok) check("out_valid_timeout", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    n_terms   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_suma_a", suma_a, 32'h0);
    check("rst_suma_b", suma_b, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // n=3, in_valid held high: 1.5 + 2.5 + 4.0 = 8.0, out_valid after edge 5
    push_exp(32'h41000000, 5'd3, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h3FC00000;
    do_start(5'd3);                      // edge 0
    @(posedge clk); #1;                  // edge 1: first term loaded
    in_data = 32'h40200000;
    @(posedge clk); #1;                  // edge 2: second term captured
    in_data = 32'h40800000;
    @(negedge clk);
    check("suma1_a", suma_a, 32'h3FC00000);
    check("suma1_b", suma_b, 32'h40200000);
    @(posedge clk); #1;                  // edge 3
    @(posedge clk); #1;                  // edge 4
    in_valid = 1'b0;
    @(negedge clk);
    check("suma2_a", suma_a, 32'h40800000);
    check("suma2_b", suma_b, 32'h40800000);
    check("n3_no_early_valid", 32'(out_valid), 32'd0);
    @(posedge clk);                      // edge 5
    @(negedge clk);
    check("n3_valid_edge5", 32'(out_valid), 32'd1);
    check("n3_count", 32'(count), 32'd3);
    @(posedge clk);
    @(negedge clk);
    check("n3_busy_drop", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // n=1: adder bypassed, result after edge 1
    push_exp(32'hC2C88000, 5'd1, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hC2C88000;
    do_start(5'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("n1_valid_edge1", 32'(out_valid), 32'd1);
    check("n1_out_data", out_data, 32'hC2C88000);
    check("n1_suma_b_zero", suma_b, 32'h0);
    @(posedge clk); #1;

    // n=0 with a start pulse while busy
    out_ready = 1'b0;
    push_exp(32'h0, 5'd0, 1'b0);
    do_start(5'd0);
    start   = 1'b1;
    n_terms = 5'd5;
    @(posedge clk); #1;                  // edge 1
    start   = 1'b0;
    n_terms = '0;
    @(negedge clk);
    check("n0_valid", 32'(out_valid), 32'd1);
    check("n0_out_data", out_data, 32'h0);
    check("n0_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_out();

    // Backpressure: gapped terms, stalled output, start pulse in ACEPTA ignored
    out_ready = 1'b0;
    push_exp(32'h41000000, 5'd3, 1'b0);
    do_start(5'd3);
    send(32'h3FC00000, 3);
    start   = 1'b1;
    n_terms = 5'd1;
    @(posedge clk); #1;
    start   = 1'b0;
    n_terms = '0;
    send(32'h40200000, 3);
    send(32'h40800000, 3);
    begin
      bit ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
        @(negedge clk);
        if (out_valid) ok = 1'b1;
      end
      if (!ok) check("bp_out_valid_timeout", 32'(out_valid), 32'd1);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_stall_valid", 32'(out_valid), 32'd1);
      check("bp_stall_data", out_data, 32'h41000000);
      check("bp_stall_count", 32'(count), 32'd3);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_out();

    // Reset asserted during SUMA aborts without output
    do_start(5'd2);
    send(32'h3FC00000, 0);
    send(32'h40200000, 0);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_suma_a", suma_a, 32'h0);
    check("abort_suma_b", suma_b, 32'h0);
    check("abort_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(32'h3FC00000, 5'd1, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h3FC00000;
    do_start(5'd1);
    wait_out();
    in_valid = 1'b0;

    // Overflow to +Inf; err sticky, then cleared by the next start
    push_exp(32'h7F800000, 5'd2, 1'b1);
    do_start(5'd2);
    send(32'h7F7FFFFF, 0);
    send(32'h7F7FFFFF, 0);
    wait_out();
    push_exp(32'h0, 5'd0, 1'b0);
    do_start(5'd0);
`ifdef ACUMULADOR_PF_ERR_EN
    check("err_cleared", 32'(err_w), 32'd0);
`endif
    wait_out();

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
